rs_station_oldest: RTL and testbench
====================================

Name: rs_station_oldest

Overview:
- Parametrised reservation station: next generation of the ALU-side RS.
- Holds up to DEPTH dispatched ops, wakes operands from CDB_CNT result buses, and issues the oldest ready op to the ALU over a valid/ready handshake.
- Operand needs come from the dispatcher (need_j/need_k flags), so the RS decodes no opcodes.
- Sits between dispatcher and ALU; cleared by ROB flush.

Parameters:
DEPTH, 16, number of entries (power of two, >=2)
CDB_CNT, 2, number of result broadcast buses
ROB_W, 4, ROB tag width
XLEN, 32, operand/immediate/pc width
TYPE_W, 6, instruction-type code width

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global stall; low freezes all state
flush_in  in  1  ROB flush
disp_valid_in  in  1  dispatch request
disp_ready_out  out  1  free entry exists
disp_type_in  in  TYPE_W  instruction type
disp_need_j_in / disp_need_k_in  in  1  operand j/k required
disp_qj_valid_in / disp_qk_valid_in  in  1  operand pending on tag
disp_qj_in / disp_qk_in  in  ROB_W  producer tags
disp_vj_in / disp_vk_in  in  XLEN  operand values
disp_imm_in, disp_pc_in  in  XLEN  immediate, pc
disp_dest_in  in  ROB_W  destination ROB tag
cdb_en_in  in  CDB_CNT  bus valid, one bit per bus
cdb_tag_in  in  CDB_CNT*ROB_W  flattened tags, bus b at [b*ROB_W +: ROB_W]
cdb_val_in  in  CDB_CNT*XLEN  flattened values
iss_valid_out  out  1  issue register holds an op
iss_ready_in  in  1  ALU accepts
iss_type_out, iss_vj_out, iss_vk_out, iss_imm_out, iss_pc_out, iss_dest_out  out  registered issue payload
count_out  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_in low, async): all entry valid bits 0, age matrix 0, iss_valid_out 0, payload outputs 0, count_out 0.
- rdy_in low: no state changes. CDB broadcasts in that cycle are lost, by design. Outputs hold.
- flush_in (rdy high) has priority over everything:
  - clears entries, iss_valid_out and count.
  - dispatch in the same cycle is dropped.
- disp_ready_out = (count_out < DEPTH), from registered state only. An entry freed this cycle does not raise it until the next cycle.
- Dispatch (disp_valid_in & disp_ready_out): write the lowest-index free entry.
  - Operand j is pending iff need_j & qj_valid. Same rule for k.
  - If a pending tag matches an active CDB in the same cycle, capture the value and write the operand as ready.
  - The new entry is marked younger than every valid entry.
- Wakeup: each cycle, every valid pending operand whose tag equals an enabled cdb_tag captures cdb_val and clears pending.
  - If several buses match, the lowest bus index wins.
- Ready entry: valid and no pending operand.
- Issue register:
  - Loads when (!iss_valid_out | iss_ready_in) and some entry is ready.
  - Selects the oldest ready entry by the age matrix.
  - Frees that entry in the same edge.
  - Without a candidate, a consumed register drops iss_valid_out.
  - Payload is stable while iss_valid_out & !iss_ready_in.
- Latency: an entry dispatched at edge E with ready operands is first loadable at edge E+1. Dispatch-to-iss_valid_out is at least 1 cycle.
- count_out next = count + dispatch_accepted - issue_loaded. Simultaneous dispatch+issue keeps the count. Full and issue in one cycle: the dispatch is refused (disp_ready_out is 0).
- An entry is never dispatched into and issued in the same edge.
- An unused operand (need=0) is never pending. Its value is passed through unchanged.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined: readiness used by the selector includes this cycle's CDB matches. An entry woken at edge E can load the issue register at edge E, with the CDB value forwarded into iss_vj_out/iss_vk_out.
- Undefined: selection uses registered readiness only. The woken entry issues at edge E+1 at the earliest.

Decomposition:
- Package rs_pkg:
  - width constants: ROB_W, XLEN, TYPE_W defaults.
  - instruction-type codes shared with the dispatcher/ALU.
  - rs_entry_t struct: valid, type, vj, vk, qj, qk, pj, pk, imm, pc, dest.
- Sub-module rs_age_select:
  - inputs: DEPTH-wide ready vector and DEPTH×DEPTH age matrix.
  - outputs: one-hot oldest grant plus valid.
  - purely combinational.

Test Plan:
- Age order: dispatch three ready ADDs (dest 1,2,3), with iss_ready_in held low until after the third dispatch, then held high -> issue order dest 1,2,3, one per cycle.
- Wakeup: dispatch SUB with qj=5 pending; later assert cdb bus1 tag=5 val=0x1234 -> next issue iss_vj_out=0x1234. Without the macro: issue exactly 1 cycle after the CDB; with RS_WAKEUP_BYPASS_EN: same edge.
- Dispatch-cycle capture: dispatch with qk=7 while cdb bus0 tag=7 val=0xAA -> entry issues with vk=0xAA, never waits.
- Full/backpressure: 16 dispatches with iss_ready_in=0 -> count_out=16, disp_ready_out=0; a 17th request is ignored. Raise iss_ready_in for one cycle -> disp_ready_out returns high next cycle.
- Flush: 5 entries held and iss_valid_out=1, then flush_in with concurrent disp_valid_in -> next cycle count_out=0, iss_valid_out=0.
- Async reset mid-operation: drop rst_in between clock edges -> outputs zero immediately. Also check that rdy_in=0 freezes count_out and the payload for 3 cycles.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared widths, ALU instruction-type codes and the reservation-station entry layout.
package rs_pkg;

    localparam int RS_ROB_W  = 4;
    localparam int RS_XLEN   = 32;
    localparam int RS_TYPE_W = 6;

    typedef enum logic [RS_TYPE_W-1:0] {
        RS_ADD  = 6'd0,
        RS_SUB  = 6'd1,
        RS_AND  = 6'd2,
        RS_OR   = 6'd3,
        RS_XOR  = 6'd4,
        RS_SLL  = 6'd5,
        RS_SRL  = 6'd6,
        RS_SRA  = 6'd7,
        RS_SLT  = 6'd8,
        RS_SLTU = 6'd9
    } rs_type_e;

    // pj/pk set means the operand still waits on tag qj/qk.
    typedef struct packed {
        logic                 valid;
        logic [RS_TYPE_W-1:0] typ;
        logic [RS_XLEN-1:0]   vj;
        logic [RS_XLEN-1:0]   vk;
        logic [RS_ROB_W-1:0]  qj;
        logic [RS_ROB_W-1:0]  qk;
        logic                 pj;
        logic                 pk;
        logic [RS_XLEN-1:0]   imm;
        logic [RS_XLEN-1:0]   pc;
        logic [RS_ROB_W-1:0]  dest;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rs_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]       ready_in,
    input  logic [DEPTH*DEPTH-1:0] age_in,
    output logic [DEPTH-1:0]       grant_out,
    output logic                   grant_vld_out
);

    // age_in[j*DEPTH+i] set means entry j is older than entry i.
    always_comb begin
        grant_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_out[i] = ready_in[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_in[j] && age_in[j*DEPTH+i]) begin
                    grant_out[i] = 1'b0;
                end
            end
        end
        grant_vld_out = |ready_in;
    end

endmodule

// File: rtl/rs_station_oldest.sv
// ALU reservation station: CDB wakeup, oldest-ready issue; RS_WAKEUP_BYPASS_EN lets a same-cycle CDB hit issue.
// Latency: dispatch to issue >= 1 cycle; wakeup to issue 1 cycle (0 with RS_WAKEUP_BYPASS_EN).
// Backpressure: disp_ready_out drops when full; issue register holds while iss_ready_in is low; rdy_in low freezes all.
module rs_station_oldest
    import rs_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CDB_CNT = 2,
    parameter int ROB_W   = RS_ROB_W,
    parameter int XLEN    = RS_XLEN,
    parameter int TYPE_W  = RS_TYPE_W
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      disp_valid_in,
    output logic                      disp_ready_out,
    input  logic [TYPE_W-1:0]         disp_type_in,
    input  logic                      disp_need_j_in,
    input  logic                      disp_need_k_in,
    input  logic                      disp_qj_valid_in,
    input  logic                      disp_qk_valid_in,
    input  logic [ROB_W-1:0]          disp_qj_in,
    input  logic [ROB_W-1:0]          disp_qk_in,
    input  logic [XLEN-1:0]           disp_vj_in,
    input  logic [XLEN-1:0]           disp_vk_in,
    input  logic [XLEN-1:0]           disp_imm_in,
    input  logic [XLEN-1:0]           disp_pc_in,
    input  logic [ROB_W-1:0]          disp_dest_in,
    input  logic [CDB_CNT-1:0]        cdb_en_in,
    input  logic [CDB_CNT*ROB_W-1:0]  cdb_tag_in,
    input  logic [CDB_CNT*XLEN-1:0]   cdb_val_in,
    output logic                      iss_valid_out,
    input  logic                      iss_ready_in,
    output logic [TYPE_W-1:0]         iss_type_out,
    output logic [XLEN-1:0]           iss_vj_out,
    output logic [XLEN-1:0]           iss_vk_out,
    output logic [XLEN-1:0]           iss_imm_out,
    output logic [XLEN-1:0]           iss_pc_out,
    output logic [ROB_W-1:0]          iss_dest_out,
    output logic [$clog2(DEPTH):0]    count_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Same layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [TYPE_W-1:0] typ;
        logic [XLEN-1:0]   vj;
        logic [XLEN-1:0]   vk;
        logic [ROB_W-1:0]  qj;
        logic [ROB_W-1:0]  qk;
        logic              pj;
        logic              pk;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [ROB_W-1:0]  dest;
    } entry_t;

    entry_t                   ent_q [DEPTH];
    entry_t                   ent_d [DEPTH];
    entry_t                   ent_w [DEPTH];
    entry_t                   disp_ent;
    entry_t                   sel_ent;
    logic [DEPTH*DEPTH-1:0]   age_q, age_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     iss_vld_q, iss_vld_d;
    logic [TYPE_W-1:0]        iss_type_q, iss_type_d;
    logic [XLEN-1:0]          iss_vj_q, iss_vj_d;
    logic [XLEN-1:0]          iss_vk_q, iss_vk_d;
    logic [XLEN-1:0]          iss_imm_q, iss_imm_d;
    logic [XLEN-1:0]          iss_pc_q, iss_pc_d;
    logic [ROB_W-1:0]         iss_dest_q, iss_dest_d;
    logic [DEPTH-1:0]         ready_vec;
    logic [DEPTH-1:0]         grant;
    logic                     sel_vld;
    logic [DEPTH-1:0]         free_oh;
    logic                     disp_fire;
    logic                     iss_load;

    // Wakeup view of every entry; descending bus loop lets the lowest bus index win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            for (int b = CDB_CNT-1; b >= 0; b--) begin
                if (cdb_en_in[b] && ent_q[i].valid && ent_q[i].pj &&
                    cdb_tag_in[b*ROB_W +: ROB_W] == ent_q[i].qj) begin
                    ent_w[i].vj = cdb_val_in[b*XLEN +: XLEN];
                    ent_w[i].pj = 1'b0;
                end
                if (cdb_en_in[b] && ent_q[i].valid && ent_q[i].pk &&
                    cdb_tag_in[b*ROB_W +: ROB_W] == ent_q[i].qk) begin
                    ent_w[i].vk = cdb_val_in[b*XLEN +: XLEN];
                    ent_w[i].pk = 1'b0;
                end
            end
`ifdef RS_WAKEUP_BYPASS_EN
            ready_vec[i] = ent_w[i].valid & ~ent_w[i].pj & ~ent_w[i].pk;
`else
            ready_vec[i] = ent_q[i].valid & ~ent_q[i].pj & ~ent_q[i].pk;
`endif
        end
    end

    always_comb begin
        disp_ent       = '0;
        disp_ent.valid = 1'b1;
        disp_ent.typ   = disp_type_in;
        disp_ent.vj    = disp_vj_in;
        disp_ent.vk    = disp_vk_in;
        disp_ent.qj    = disp_qj_in;
        disp_ent.qk    = disp_qk_in;
        disp_ent.pj    = disp_need_j_in & disp_qj_valid_in;
        disp_ent.pk    = disp_need_k_in & disp_qk_valid_in;
        disp_ent.imm   = disp_imm_in;
        disp_ent.pc    = disp_pc_in;
        disp_ent.dest  = disp_dest_in;
        for (int b = CDB_CNT-1; b >= 0; b--) begin
            if (cdb_en_in[b] && disp_need_j_in && disp_qj_valid_in &&
                cdb_tag_in[b*ROB_W +: ROB_W] == disp_qj_in) begin
                disp_ent.vj = cdb_val_in[b*XLEN +: XLEN];
                disp_ent.pj = 1'b0;
            end
            if (cdb_en_in[b] && disp_need_k_in && disp_qk_valid_in &&
                cdb_tag_in[b*ROB_W +: ROB_W] == disp_qk_in) begin
                disp_ent.vk = cdb_val_in[b*XLEN +: XLEN];
                disp_ent.pk = 1'b0;
            end
        end
    end

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .ready_in      (ready_vec),
        .age_in        (age_q),
        .grant_out     (grant),
        .grant_vld_out (sel_vld)
    );

    // Lowest-index free slot from registered valid bits only.
    always_comb begin
        free_oh = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent_w[i];
            end
        end
    end

    assign disp_ready_out = (count_q < FULL_CNT);
    assign disp_fire      = disp_valid_in & disp_ready_out;
    assign iss_load       = (~iss_vld_q | iss_ready_in) & sel_vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        age_d      = age_q;
        count_d    = count_q;
        iss_vld_d  = iss_vld_q;
        iss_type_d = iss_type_q;
        iss_vj_d   = iss_vj_q;
        iss_vk_d   = iss_vk_q;
        iss_imm_d  = iss_imm_q;
        iss_pc_d   = iss_pc_q;
        iss_dest_d = iss_dest_q;
        if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].valid = 1'b0;
                end
                count_d   = '0;
                iss_vld_d = 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i] = ent_w[i];
                    if (iss_load && grant[i]) begin
                        ent_d[i].valid = 1'b0;
                    end
                    // New entry: every currently valid entry becomes older than it.
                    if (disp_fire && free_oh[i]) begin
                        ent_d[i] = disp_ent;
                        for (int j = 0; j < DEPTH; j++) begin
                            age_d[j*DEPTH+i] = ent_q[j].valid;
                        end
                        for (int j = 0; j < DEPTH; j++) begin
                            age_d[i*DEPTH+j] = 1'b0;
                        end
                    end
                end
                if (iss_load) begin
                    iss_vld_d  = 1'b1;
                    iss_type_d = sel_ent.typ;
                    iss_vj_d   = sel_ent.vj;
                    iss_vk_d   = sel_ent.vk;
                    iss_imm_d  = sel_ent.imm;
                    iss_pc_d   = sel_ent.pc;
                    iss_dest_d = sel_ent.dest;
                end else if (iss_ready_in) begin
                    iss_vld_d = 1'b0;
                end
                count_d = count_q + {{(CNT_W-1){1'b0}}, disp_fire}
                                  - {{(CNT_W-1){1'b0}}, iss_load};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            age_q      <= '0;
            count_q    <= '0;
            iss_vld_q  <= 1'b0;
            iss_type_q <= '0;
            iss_vj_q   <= '0;
            iss_vk_q   <= '0;
            iss_imm_q  <= '0;
            iss_pc_q   <= '0;
            iss_dest_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            age_q      <= age_d;
            count_q    <= count_d;
            iss_vld_q  <= iss_vld_d;
            iss_type_q <= iss_type_d;
            iss_vj_q   <= iss_vj_d;
            iss_vk_q   <= iss_vk_d;
            iss_imm_q  <= iss_imm_d;
            iss_pc_q   <= iss_pc_d;
            iss_dest_q <= iss_dest_d;
        end
    end

    assign iss_valid_out = iss_vld_q;
    assign iss_type_out  = iss_type_q;
    assign iss_vj_out    = iss_vj_q;
    assign iss_vk_out    = iss_vk_q;
    assign iss_imm_out   = iss_imm_q;
    assign iss_pc_out    = iss_pc_q;
    assign iss_dest_out  = iss_dest_q;
    assign count_out     = count_q;

endmodule

// File: tb/tb_rs_station_oldest.sv
// Directed bench for rs_station_oldest: age order, wakeup, dispatch capture, full, freeze, flush, async reset.
module tb_rs_station_oldest;
    import rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        disp_valid_in;
    logic        disp_ready_out;
    logic [5:0]  disp_type_in;
    logic        disp_need_j_in, disp_need_k_in;
    logic        disp_qj_valid_in, disp_qk_valid_in;
    logic [3:0]  disp_qj_in, disp_qk_in;
    logic [31:0] disp_vj_in, disp_vk_in, disp_imm_in, disp_pc_in;
    logic [3:0]  disp_dest_in;
    logic [1:0]  cdb_en_in;
    logic [7:0]  cdb_tag_in;
    logic [63:0] cdb_val_in;
    logic        iss_valid_out;
    logic        iss_ready_in;
    logic [5:0]  iss_type_out;
    logic [31:0] iss_vj_out, iss_vk_out, iss_imm_out, iss_pc_out;
    logic [3:0]  iss_dest_out;
    logic [4:0]  count_out;

    int total;
    int bad;

    rs_station_oldest dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_in         (flush_in),
        .disp_valid_in    (disp_valid_in),
        .disp_ready_out   (disp_ready_out),
        .disp_type_in     (disp_type_in),
        .disp_need_j_in   (disp_need_j_in),
        .disp_need_k_in   (disp_need_k_in),
        .disp_qj_valid_in (disp_qj_valid_in),
        .disp_qk_valid_in (disp_qk_valid_in),
        .disp_qj_in       (disp_qj_in),
        .disp_qk_in       (disp_qk_in),
        .disp_vj_in       (disp_vj_in),
        .disp_vk_in       (disp_vk_in),
        .disp_imm_in      (disp_imm_in),
        .disp_pc_in       (disp_pc_in),
        .disp_dest_in     (disp_dest_in),
        .cdb_en_in        (cdb_en_in),
        .cdb_tag_in       (cdb_tag_in),
        .cdb_val_in       (cdb_val_in),
        .iss_valid_out    (iss_valid_out),
        .iss_ready_in     (iss_ready_in),
        .iss_type_out     (iss_type_out),
        .iss_vj_out       (iss_vj_out),
        .iss_vk_out       (iss_vk_out),
        .iss_imm_out      (iss_imm_out),
        .iss_pc_out       (iss_pc_out),
        .iss_dest_out     (iss_dest_out),
        .count_out        (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_disp(input logic [5:0] typ,
                            input logic nj, input logic qjv, input logic [3:0] tj, input logic [31:0] valj,
                            input logic nk, input logic qkv, input logic [3:0] tk, input logic [31:0] valk,
                            input logic [3:0] d);
        disp_valid_in    = 1'b1;
        disp_type_in     = typ;
        disp_need_j_in   = nj;
        disp_qj_valid_in = qjv;
        disp_qj_in       = tj;
        disp_vj_in       = valj;
        disp_need_k_in   = nk;
        disp_qk_valid_in = qkv;
        disp_qk_in       = tk;
        disp_vk_in       = valk;
        disp_dest_in     = d;
        disp_imm_in      = 32'h1000 + {28'h0, d};
        disp_pc_in       = 32'h4000 + {26'h0, d, 2'b00};
    endtask

    task automatic set_rdy(input logic [5:0] typ, input logic [31:0] valj, input logic [31:0] valk,
                           input logic [3:0] d);
        set_disp(typ, 1'b1, 1'b0, 4'd0, valj, 1'b1, 1'b0, 4'd0, valk, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; iss_ready_in = 1'b0;
        cdb_en_in = 2'b00; cdb_tag_in = 8'h00; cdb_val_in = 64'h0;
        set_rdy(6'd0, 32'h0, 32'h0, 4'd0);
        disp_valid_in = 1'b0;
        #1 rst_in = 1'b0;
        #2;
        chk("rst_count", 32'(count_out), 0);
        chk("rst_iss_valid", 32'(iss_valid_out), 0);
        chk("rst_iss_dest", 32'(iss_dest_out), 0);
        chk("rst_disp_ready", 32'(disp_ready_out), 1);
        #9 rst_in = 1'b1;
        tick();

        // Age order: three ready ADDs, consumer stalled until all dispatched
        set_rdy(RS_ADD, 32'd10, 32'd20, 4'd1);
        tick();
        chk("age_cnt1", 32'(count_out), 1);
        chk("age_no_same_edge_issue", 32'(iss_valid_out), 0);
        set_rdy(RS_ADD, 32'd11, 32'd21, 4'd2);
        tick();
        chk("age_iss1_valid", 32'(iss_valid_out), 1);
        chk("age_iss1_dest", 32'(iss_dest_out), 1);
        set_rdy(RS_ADD, 32'd12, 32'd22, 4'd3);
        tick();
        chk("age_cnt2", 32'(count_out), 2);
        chk("age_hold_dest", 32'(iss_dest_out), 1);
        chk("age_hold_vj", iss_vj_out, 10);
        disp_valid_in = 1'b0;
        iss_ready_in  = 1'b1;
        tick();
        chk("age_iss2_dest", 32'(iss_dest_out), 2);
        chk("age_iss2_vk", iss_vk_out, 21);
        chk("age_cnt_after2", 32'(count_out), 1);
        tick();
        chk("age_iss3_dest", 32'(iss_dest_out), 3);
        chk("age_cnt_after3", 32'(count_out), 0);
        tick();
        chk("age_drain_valid", 32'(iss_valid_out), 0);

        // Wakeup: SUB waiting on tag 5, broadcast on bus 1
        set_disp(RS_SUB, 1'b1, 1'b1, 4'd5, 32'h0, 1'b1, 1'b0, 4'd0, 32'd3, 4'd4);
        tick();
        chk("wk_cnt", 32'(count_out), 1);
        chk("wk_pending_valid0", 32'(iss_valid_out), 0);
        disp_valid_in = 1'b0;
        tick();
        chk("wk_still_pending", 32'(iss_valid_out), 0);
        cdb_en_in  = 2'b11;
        cdb_tag_in = {4'd5, 4'd9};
        cdb_val_in = {32'h0000_1234, 32'h0000_DEAD};
        tick();
        cdb_en_in = 2'b00;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("wk_byp_valid", 32'(iss_valid_out), 1);
        chk("wk_byp_vj", iss_vj_out, 32'h1234);
        chk("wk_byp_vk", iss_vk_out, 3);
        chk("wk_byp_imm", iss_imm_out, 32'h1004);
        chk("wk_byp_pc", iss_pc_out, 32'h4010);
        chk("wk_byp_cnt", 32'(count_out), 0);
        tick();
        chk("wk_byp_drain", 32'(iss_valid_out), 0);
`else
        chk("wk_no_byp_valid", 32'(iss_valid_out), 0);
        chk("wk_no_byp_cnt", 32'(count_out), 1);
        tick();
        chk("wk_valid", 32'(iss_valid_out), 1);
        chk("wk_vj", iss_vj_out, 32'h1234);
        chk("wk_vk", iss_vk_out, 3);
        chk("wk_type", 32'(iss_type_out), 32'(RS_SUB));
        chk("wk_dest", 32'(iss_dest_out), 4);
        chk("wk_imm", iss_imm_out, 32'h1004);
        chk("wk_pc", iss_pc_out, 32'h4010);
        tick();
        chk("wk_drain", 32'(iss_valid_out), 0);
`endif

        // Dispatch-cycle capture on k; j is unused though its tag is flagged
        set_disp(RS_XOR, 1'b0, 1'b1, 4'd3, 32'h55, 1'b1, 1'b1, 4'd7, 32'h0, 4'd6);
        cdb_en_in  = 2'b11;
        cdb_tag_in = {4'd7, 4'd7};
        cdb_val_in = {32'h0000_00BB, 32'h0000_00AA};
        tick();
        chk("cap_cnt", 32'(count_out), 1);
        chk("cap_same_edge", 32'(iss_valid_out), 0);
        disp_valid_in = 1'b0;
        cdb_en_in     = 2'b00;
        tick();
        chk("cap_valid", 32'(iss_valid_out), 1);
        chk("cap_vk", iss_vk_out, 32'hAA);
        chk("cap_vj_pass", iss_vj_out, 32'h55);
        chk("cap_dest", 32'(iss_dest_out), 6);
        tick();
        chk("cap_drain", 32'(iss_valid_out), 0);

        // Full: one op parks in the issue register, then 16 more fill the station
        iss_ready_in = 1'b0;
        set_rdy(RS_ADD, 32'hE0, 32'h0, 4'd14);
        tick();
        for (int i = 0; i < 16; i++) begin
            set_rdy(RS_ADD, 32'h100 + 32'(i), 32'h0, 4'(i));
            tick();
        end
        chk("full_cnt", 32'(count_out), 16);
        chk("full_ready", 32'(disp_ready_out), 0);
        chk("full_iss_dest", 32'(iss_dest_out), 14);
        set_rdy(RS_ADD, 32'h999, 32'h0, 4'd13);
        tick();
        chk("full_17th_cnt", 32'(count_out), 16);
        chk("full_17th_ready", 32'(disp_ready_out), 0);
        iss_ready_in = 1'b1;
        tick();
        chk("full_issue_cnt", 32'(count_out), 15);
        chk("full_ready_back", 32'(disp_ready_out), 1);
        chk("full_oldest_dest", 32'(iss_dest_out), 0);
        chk("full_oldest_vj", iss_vj_out, 32'h100);
        iss_ready_in  = 1'b0;
        disp_valid_in = 1'b0;
        flush_in      = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush1_cnt", 32'(count_out), 0);
        chk("flush1_valid", 32'(iss_valid_out), 0);

        // Five entries held plus one in the issue register
        for (int i = 0; i < 6; i++) begin
            set_rdy(RS_ADD, 32'h200 + 32'(i), 32'h0, 4'(i + 1));
            tick();
        end
        disp_valid_in = 1'b0;
        chk("hold5_cnt", 32'(count_out), 5);
        chk("hold5_valid", 32'(iss_valid_out), 1);
        chk("hold5_dest", 32'(iss_dest_out), 1);

        // rdy_in low: everything frozen despite consumer, dispatch and CDB activity
        rdy_in       = 1'b0;
        iss_ready_in = 1'b1;
        set_rdy(RS_ADD, 32'h777, 32'h0, 4'd12);
        cdb_en_in  = 2'b11;
        cdb_tag_in = {4'd2, 4'd3};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_cnt", 32'(count_out), 5);
            chk("frz_valid", 32'(iss_valid_out), 1);
            chk("frz_vj", iss_vj_out, 32'h200);
        end
        rdy_in       = 1'b1;
        cdb_en_in    = 2'b00;
        iss_ready_in = 1'b0;
        flush_in     = 1'b1;
        tick();
        chk("flush_cnt", 32'(count_out), 0);
        chk("flush_valid", 32'(iss_valid_out), 0);
        flush_in      = 1'b0;
        disp_valid_in = 1'b0;
        iss_ready_in  = 1'b1;
        tick();
        chk("flush_dropped_disp", 32'(iss_valid_out), 0);
        chk("flush_cnt_stays", 32'(count_out), 0);

        // Asynchronous reset between edges
        iss_ready_in = 1'b0;
        set_rdy(RS_ADD, 32'h300, 32'h0, 4'd2);
        tick();
        set_rdy(RS_ADD, 32'h301, 32'h0, 4'd3);
        tick();
        disp_valid_in = 1'b0;
        chk("pre_rst_cnt", 32'(count_out), 1);
        chk("pre_rst_vj", iss_vj_out, 32'h300);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_cnt", 32'(count_out), 0);
        chk("arst_valid", 32'(iss_valid_out), 0);
        chk("arst_vj", iss_vj_out, 0);
        chk("arst_dest", 32'(iss_dest_out), 0);
        #3 rst_in = 1'b1;
        tick();
        chk("post_rst_valid", 32'(iss_valid_out), 0);
        chk("post_rst_cnt", 32'(count_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
